// File: rtl/decode_stage.sv
// Decode stage of a five-stage RV32I pipeline: register file with write-through
// bypass, main/ALU control decoding, immediate extension and the D/E register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  input  logic            StallE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
  } de_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign rs1       = InstrD[19:15];
  assign rs2       = InstrD[24:20];
  assign rd        = InstrD[11:7];

  // ---------------- register file ----------------
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_active;

  assign wr_active = RegWriteW && (RdW != 5'd0);

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi] <= '0;
        end else if (gi != 0 && wr_active && RdW == 5'(gi)) begin
          regs[gi] <= ResultW;
        end
      end
    end
  endgenerate

  logic [XLEN-1:0] rd1_val;
  logic [XLEN-1:0] rd2_val;

  // Writeback lands on the same edge that loads D/E, so forward it here.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs1 != 5'd0) rd1_val = (wr_active && RdW == rs1) ? ResultW : regs[rs1];
    if (rs2 != 5'd0) rd2_val = (wr_active && RdW == rs2) ? ResultW : regs[rs2];
  end

  // ---------------- main decoder ----------------
  logic       reg_write;
  logic [1:0] imm_src;
  logic       alu_src;
  logic       mem_write;
  logic [1:0] result_src;
  logic       branch;
  logic [1:0] alu_op;
  logic       jump;

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_SW: begin
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_BEQ: begin
        imm_src = 2'b10;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- ALU decoder ----------------
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // ---------------- immediate extender ----------------
  logic [31:0] imm_ext;

  always_comb begin
    case (imm_src)
      2'b00:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
  end

  // ---------------- D/E pipeline register ----------------
  de_t de_next;
  de_t de_reg;

  always_comb begin
    de_next             = '0;
    de_next.rd1         = rd1_val;
    de_next.rd2         = rd2_val;
    de_next.imm         = XLEN'(imm_ext);
    de_next.pc          = PCD;
    de_next.pc_plus4    = PCPlus4D;
    de_next.rs1         = rs1;
    de_next.rs2         = rs2;
    de_next.rd          = rd;
    de_next.reg_write   = reg_write;
    de_next.mem_write   = mem_write;
    de_next.jump        = jump;
    de_next.branch      = branch;
    de_next.alu_src     = alu_src;
    de_next.result_src  = result_src;
    de_next.alu_control = alu_control;
  end

  // Flush beats stall so a squashed slot never lingers behind a held stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_reg <= '0;
    end else if (FlushE) begin
      de_reg <= '0;
    end else if (!StallE) begin
      de_reg <= de_next;
    end
  end

  assign RD1E        = de_reg.rd1;
  assign RD2E        = de_reg.rd2;
  assign ImmExtE     = de_reg.imm;
  assign PCE         = de_reg.pc;
  assign PCPlus4E    = de_reg.pc_plus4;
  assign Rs1E        = de_reg.rs1;
  assign Rs2E        = de_reg.rs2;
  assign RdE         = de_reg.rd;
  assign RegWriteE   = de_reg.reg_write;
  assign MemWriteE   = de_reg.mem_write;
  assign JumpE       = de_reg.jump;
  assign BranchE     = de_reg.branch;
  assign ALUSrcE     = de_reg.alu_src;
  assign ResultSrcE  = de_reg.result_src;
  assign ALUControlE = de_reg.alu_control;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed pipeline scenarios followed by
// randomized instructions checked against a behavioural decode model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE, StallE;
  logic [4:0]  RdW;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .FlushE(FlushE), .StallE(StallE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  logic [31:0] model_regs [32];

  function automatic exp_t actual();
    exp_t a;
    a.rd1 = RD1E; a.rd2 = RD2E; a.imm = ImmExtE; a.pc = PCE; a.pcp4 = PCPlus4E;
    a.rs1 = Rs1E; a.rs2 = Rs2E; a.rd = RdE;
    a.reg_write = RegWriteE; a.mem_write = MemWriteE; a.jump = JumpE;
    a.branch = BranchE; a.alu_src = ALUSrcE;
    a.result_src = ResultSrcE; a.alu_control = ALUControlE;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, req);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] t;
    t = v << (32 - bits);
    return $signed(t) >>> (32 - bits);
  endfunction

  // Register value as seen by decode this cycle, including the writeback in flight.
  function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic rw,
                                          input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 0) return 32'd0;
    if (rw && rdw == idx) return res;
    return model_regs[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] pcp4, input logic rw,
                                 input logic [4:0] rdw, input logic [31:0] res);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [2:0]  arith;
    imm_i = sext({20'd0, ins[31:20]}, 12);
    imm_s = sext({20'd0, ins[31:25], ins[11:7]}, 12);
    imm_b = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
    imm_j = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
    case (ins[14:12])
      3'd0:    arith = (ins[5] && ins[30]) ? 3'b001 : 3'b000;
      3'd2:    arith = 3'b101;
      3'd6:    arith = 3'b011;
      3'd7:    arith = 3'b010;
      default: arith = 3'b000;
    endcase
    e = '0;
    e.rd1  = rf_read(ins[19:15], rw, rdw, res);
    e.rd2  = rf_read(ins[24:20], rw, rdw, res);
    e.pc   = pc;
    e.pcp4 = pcp4;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rd   = ins[11:7];
    e.imm  = imm_i;
    case (ins[6:0])
      7'b0000011: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; end
      7'b0100011: begin e.imm = imm_s; e.alu_src = 1; e.mem_write = 1; end
      7'b0110011: begin e.reg_write = 1; e.alu_control = arith; end
      7'b1100011: begin e.imm = imm_b; e.branch = 1; e.alu_control = 3'b001; end
      7'b0010011: begin e.reg_write = 1; e.alu_src = 1; e.alu_control = arith; end
      7'b1101111: begin e.imm = imm_j; e.reg_write = 1; e.result_src = 2'b10; e.jump = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one D-stage cycle and queue the E-stage contents expected after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic rw,
                      input logic [4:0] rdw, input logic [31:0] res,
                      input logic fl, input logic st);
    exp_t e;
    @(negedge clk);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = rw; RdW = rdw; ResultW = res; FlushE = fl; StallE = st;
    if (fl)      e = '0;
    else if (st) e = last_exp;
    else         e = model(ins, pc, pc + 32'd4, rw, rdw, res);
    last_exp = e;
    exp_q.push_back(e);
    if (rw && rdw != 0) model_regs[rdw] = res;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    RegWriteW = 1'b0; FlushE = 1'b0; StallE = 1'b0;
    #1 chk("async_reset_outputs_zero", 32'(actual() != '0), 32'd0);
    foreach (model_regs[i]) model_regs[i] = '0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: each edge that follows issued stimulus is compared against the queue.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL de_bundle: got %h expected %h", a, e);
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    logic [31:0] ins;
    int waited;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;
    ops[4] = 7'b0010011; ops[5] = 7'b1101111; ops[6] = 7'b1111111; ops[7] = 7'b0001111;
    foreach (model_regs[i]) model_regs[i] = '0;
    last_exp = '0;
    rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0; StallE = 1'b0;
    #1 chk("reset_outputs_zero", 32'(actual() != '0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // write x5 then read it
    step(32'h0000_0013, 32'h100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    step(32'h0002_80B3, 32'h104, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("add_rd1", RD1E, 32'hDEADBEEF);
    chk("add_rd2", RD2E, 32'd0);
    chk("add_ctrl", {RegWriteE, ALUControlE, RdE}, {1'b1, 3'b000, 5'd1});
    // bypass and x0 write
    step(32'h0003_0133, 32'h108, 1'b1, 5'd6, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("bypass_rd1", RD1E, 32'd7);
    step(32'h0000_0013, 32'h10C, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
    step(32'h0000_0133, 32'h110, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("x0_reads_zero", RD1E, 32'd0);
    // immediates
    step(32'hFFC1_A103, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("lw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("lw_ctrl", {ResultSrcE, ALUSrcE}, {2'b01, 1'b1});
    step(32'hFE20_8CE3, 32'h118, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("beq_ctrl", {BranchE, ALUControlE}, {1'b1, 3'b001});
    step(32'h0010_00EF, 32'h11C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("jal_imm", ImmExtE, 32'h0000_0800);
    chk("jal_ctrl", {JumpE, ResultSrcE}, {1'b1, 2'b10});
    // sub, stall twice, flush with stall
    step(32'h4020_81B3, 32'h120, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(32'h0000_0013, 32'h124, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    step(32'h0000_0013, 32'h128, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("stall_hold_sub", {PCE[15:0], 13'd0, ALUControlE}, {16'h0120, 13'd0, 3'b001});
    step(32'h4020_81B3, 32'h12C, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("flush_over_stall", 32'(actual() != '0), 32'd0);
    step(32'h0000_007F, 32'h130, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("illegal_ctrl", {28'd0, RegWriteE, MemWriteE, BranchE, JumpE}, 32'd0);

    // reset mid-run clears the register file
    do_reset();
    step(32'h0002_80B3, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("x5_cleared", RD1E, 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      step(ins, {$urandom, 2'b00} & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
           5'($urandom), $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      if (n == 200) do_reset();
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
